// File: rtl/result_fmt_pkg.sv
// result_fmt_pkg: shared state encoding and constants for the BCD result formatter
package result_fmt_pkg;
   typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
   localparam int BCD_ACC_DIGITS = 5;
   localparam logic [15:0] BCD_SAT_VALUE = 16'h9999;
   localparam int CNT_W = 5;
endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one combinational double-dabble iteration (add-3 per nibble, then shift left)
module bcd_dabble_step #(
   parameter int WIDTH = 16,
   parameter int DIGITS = 5
) (
   input  logic [DIGITS*4+WIDTH-1:0] vec,
   output logic [DIGITS*4+WIDTH-1:0] vec_next
);
   logic [DIGITS*4-1:0] adj;
   for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      assign adj[d*4+:4] = (vec[WIDTH+d*4+:4] >= 4'd5) ? vec[WIDTH+d*4+:4] + 4'd3 : vec[WIDTH+d*4+:4];
   end
   assign vec_next = {adj, vec[WIDTH-1:0]} << 1;
endmodule

// File: rtl/result_bcd_formatter.sv
// result_bcd_formatter: captures two binary counts and converts them to packed BCD for the display.
// Define RESULT_BCD_SATURATE_EN to show 9999 for a channel above 9999 instead of its low 4 digits.
module result_bcd_formatter
   import result_fmt_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGITS = 4
) (
   input  logic                  in_clk,
   input  logic                  in_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_attempt,
   input  logic [WIDTH-1:0]      in_broken,
   output logic [2*DIGITS*4-1:0] out_data,
   output logic                  out_valid,
   output logic [1:0]            out_overflow
);
   localparam int BCD_W = BCD_ACC_DIGITS*4;
   localparam int VEC_W = BCD_W+WIDTH;
   state_t state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [VEC_W-1:0] att_vec, brk_vec, att_next, brk_next;
   logic [BCD_W-1:0] att_bcd, brk_bcd;
   logic [DIGITS*4-1:0] att_show, brk_show;
   logic att_ovf, brk_ovf;

   bcd_dabble_step #(.WIDTH(WIDTH), .DIGITS(BCD_ACC_DIGITS)) u_att (.vec(att_vec), .vec_next(att_next));
   bcd_dabble_step #(.WIDTH(WIDTH), .DIGITS(BCD_ACC_DIGITS)) u_brk (.vec(brk_vec), .vec_next(brk_next));

   assign in_ready = (state == IDLE);
   assign att_bcd = att_vec[VEC_W-1:WIDTH];
   assign brk_bcd = brk_vec[VEC_W-1:WIDTH];
   assign att_ovf = |att_bcd[BCD_W-1:DIGITS*4];
   assign brk_ovf = |brk_bcd[BCD_W-1:DIGITS*4];
`ifdef RESULT_BCD_SATURATE_EN
   assign att_show = att_ovf ? (DIGITS*4)'(BCD_SAT_VALUE) : att_bcd[DIGITS*4-1:0];
   assign brk_show = brk_ovf ? (DIGITS*4)'(BCD_SAT_VALUE) : brk_bcd[DIGITS*4-1:0];
`else
   assign att_show = att_bcd[DIGITS*4-1:0];
   assign brk_show = brk_bcd[DIGITS*4-1:0];
`endif

   always_comb begin
      state_nxt = state;
      state_nxt = (state == IDLE && in_valid) ? CONVERT :
                  (state == CONVERT && cnt == CNT_W'(WIDTH-1)) ? DONE :
                  (state == DONE) ? IDLE : state;
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state <= IDLE;
         cnt <= '0;
         att_vec <= '0;
         brk_vec <= '0;
         out_data <= '0;
         out_valid <= 1'b0;
         out_overflow <= 2'b00;
      end else begin
         state <= state_nxt;
         out_valid <= (state == DONE);
         if (in_valid && in_ready) begin
            att_vec <= {BCD_W'(0), in_attempt};
            brk_vec <= {BCD_W'(0), in_broken};
            cnt <= '0;
         end else if (state == CONVERT) begin
            att_vec <= att_next;
            brk_vec <= brk_next;
            cnt <= cnt + 1'b1;
         end
         if (state == DONE) begin
            out_data <= {att_show, brk_show};
            out_overflow <= {att_ovf, brk_ovf};
         end
      end
   end
endmodule

// File: tb/tb_result_bcd_formatter.sv
// tb_result_bcd_formatter: directed checks of latency, BCD values, overflow, back-to-back and reset abort
module tb_result_bcd_formatter;
   logic in_clk = 1'b0;
   logic in_rst = 1'b1;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [15:0] in_attempt = '0;
   logic [15:0] in_broken = '0;
   logic [31:0] out_data;
   logic out_valid;
   logic [1:0] out_overflow;
   int n_pass = 0;
   int n_total = 0;

   result_bcd_formatter dut (
      .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_attempt(in_attempt), .in_broken(in_broken),
      .out_data(out_data), .out_valid(out_valid), .out_overflow(out_overflow)
   );

   always #5 in_clk = ~in_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [15:0] bcd4(input int v);
      return {4'(v/1000%10), 4'(v/100%10), 4'(v/10%10), 4'(v%10)};
   endfunction

   task automatic convert(input logic [15:0] a, input logic [15:0] b, input logic [31:0] ed, input logic [1:0] eo);
      int n;
      n = 0;
      @(negedge in_clk);
      in_attempt = a;
      in_broken = b;
      in_valid = 1'b1;
      check("ready_before", 32'(in_ready), 32'd1);
      @(posedge in_clk);
      #1 in_valid = 1'b0;
      do begin
         @(posedge in_clk);
         n++;
         #1;
      end while (!out_valid && n < 40);
      check("latency", 32'(n), 32'd17);
      check("data", out_data, ed);
      check("overflow", 32'(out_overflow), 32'(eo));
      @(posedge in_clk);
      #1;
      check("pulse_single", 32'(out_valid), 32'd0);
      check("ready_after", 32'(in_ready), 32'd1);
   endtask

   initial begin
      int last_pulse, low_run, pulses;
      logic [31:0] exp_data;
      repeat (3) @(posedge in_clk);
      @(negedge in_clk);
      in_rst = 1'b0;
      check("rst_data", out_data, 32'h0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_ovf", 32'(out_overflow), 32'd0);

      convert(16'd1234, 16'd56, 32'h1234_0056, 2'b00);
      convert(16'd0, 16'd0, 32'h0000_0000, 2'b00);
`ifdef RESULT_BCD_SATURATE_EN
      convert(16'd9999, 16'd10000, 32'h9999_9999, 2'b01);
      convert(16'd65535, 16'd65535, 32'h9999_9999, 2'b11);
`else
      convert(16'd9999, 16'd10000, 32'h9999_0000, 2'b01);
      convert(16'd65535, 16'd65535, 32'h5535_5535, 2'b11);
`endif

      // valid held high with inputs changing every cycle; only IDLE-cycle values count
      last_pulse = -1;
      low_run = 0;
      pulses = 0;
      exp_data = '0;
      for (int i = 0; i <= 54; i++) begin
         @(negedge in_clk);
         if (out_valid) begin
            pulses++;
            check("stream_data", out_data, exp_data);
            if (last_pulse >= 0) check("stream_period", 32'(i - last_pulse), 32'd18);
            last_pulse = i;
         end
         if (in_ready) begin
            if (low_run > 0) check("stream_ready_low", 32'(low_run), 32'd17);
            low_run = 0;
         end else low_run++;
         in_valid = (i <= 36);
         in_attempt = 16'(100 + i);
         in_broken = 16'(i * 3);
         if (in_ready && in_valid) exp_data = {bcd4(100 + i), bcd4(i * 3)};
      end
      in_valid = 1'b0;
      check("stream_pulses", 32'(pulses), 32'd3);

      // abort a conversion at iteration 8
      @(negedge in_clk);
      in_attempt = 16'd4321;
      in_broken = 16'd7;
      in_valid = 1'b1;
      @(posedge in_clk);
      #1 in_valid = 1'b0;
      repeat (8) @(posedge in_clk);
      @(negedge in_clk);
      in_rst = 1'b1;
      @(posedge in_clk);
      #1;
      check("abort_data", out_data, 32'h0);
      check("abort_ovf", 32'(out_overflow), 32'd0);
      check("abort_ready", 32'(in_ready), 32'd1);
      // reset together with valid: nothing may be captured
      in_valid = 1'b1;
      @(posedge in_clk);
      #1;
      in_rst = 1'b0;
      in_valid = 1'b0;
      pulses = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge in_clk);
         if (out_valid) pulses++;
         if (!in_ready) pulses += 100;
      end
      check("abort_no_pulse", 32'(pulses), 32'd0);
      convert(16'd4321, 16'd7, 32'h4321_0007, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
